// File: rtl/riscv_decode_pkg.sv
// Shared types and opcode constants for the RV32I multi-lane decode stage.
package riscv_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ERR = 3'd6
  } format_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    format_e     format;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } decoded_lane_t;

endpackage

// File: rtl/riscv_decode_lane.sv
// Combinational single-lane RV32I decoder: fields, format, immediate and illegal flag.
module riscv_decode_lane
  import riscv_decode_pkg::*;
#(
  parameter int SIGN_EXT_IMM = 1
) (
  input  logic [31:0]   instr,
  input  logic          valid,
  output decoded_lane_t dec
);

  format_e fmt;
  logic    fill;
  logic    bad;

  // Every RV32I immediate carries its sign in instr[31].
  assign fill = (SIGN_EXT_IMM != 0) ? instr[31] : 1'b0;

  always_comb begin
    fmt = FMT_ERR;
    case (instr[6:0])
      OPC_OP:                      fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                   fmt = FMT_S;
      OPC_BRANCH:                  fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:          fmt = FMT_U;
      OPC_JAL:                     fmt = FMT_J;
      default:                     fmt = FMT_ERR;
    endcase
  end

  assign bad = (fmt == FMT_ERR) || (instr[1:0] != 2'b11);

  always_comb begin
    dec         = '0;
    dec.format  = fmt;
    dec.op      = instr[6:0];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.illegal = valid & bad;
    case (fmt)
      FMT_I:   dec.imm = {{20{fill}}, instr[31:20]};
      FMT_S:   dec.imm = {{20{fill}}, instr[31:25], instr[11:7]};
      FMT_B:   dec.imm = {{19{fill}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   dec.imm = {instr[31:12], 12'b0};
      FMT_J:   dec.imm = {{11{fill}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: dec.imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered multi-lane RV32I decode stage with a 2-entry skid buffer and a
// running count of decoded valid lanes.
module riscv_decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int NUM_LANES    = 1,
  parameter int SIGN_EXT_IMM = 1,
  parameter int CNT_W        = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [32*NUM_LANES-1:0] instr_i,
  input  logic [NUM_LANES-1:0]   lane_mask_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NUM_LANES-1:0]   lane_mask_o,
  output logic [3*NUM_LANES-1:0] format_o,
  output logic [7*NUM_LANES-1:0] op_o,
  output logic [3*NUM_LANES-1:0] funct3_o,
  output logic [7*NUM_LANES-1:0] funct7_o,
  output logic [5*NUM_LANES-1:0] rd_o,
  output logic [5*NUM_LANES-1:0] rs1_o,
  output logic [5*NUM_LANES-1:0] rs2_o,
  output logic [32*NUM_LANES-1:0] imm_o,
  output logic [NUM_LANES-1:0]   illegal_o,
  output logic [CNT_W-1:0]       decode_cnt_o,
  output logic [1:0]             state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds data while valid && !ready, and ready never
  // depends combinationally on the same-cycle valid of the other side.

  decoded_lane_t [NUM_LANES-1:0] dec_new;
  decoded_lane_t [NUM_LANES-1:0] head_q;
  decoded_lane_t [NUM_LANES-1:0] skid_q;
  logic [NUM_LANES-1:0]          head_mask_q;
  logic [NUM_LANES-1:0]          skid_mask_q;

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    riscv_decode_lane #(.SIGN_EXT_IMM(SIGN_EXT_IMM)) u_lane (
      .instr (instr_i[32*k +: 32]),
      .valid (lane_mask_i[k]),
      .dec   (dec_new[k])
    );

    assign format_o[3*k +: 3]  = head_q[k].format;
    assign op_o[7*k +: 7]      = head_q[k].op;
    assign funct3_o[3*k +: 3]  = head_q[k].funct3;
    assign funct7_o[7*k +: 7]  = head_q[k].funct7;
    assign rd_o[5*k +: 5]      = head_q[k].rd;
    assign rs1_o[5*k +: 5]     = head_q[k].rs1;
    assign rs2_o[5*k +: 5]     = head_q[k].rs2;
    assign imm_o[32*k +: 32]   = head_q[k].imm;
    assign illegal_o[k]        = head_q[k].illegal;
  end

  assign in_fire  = in_valid_i && in_ready_q;
  assign out_fire = out_valid_q && out_ready_i;

  always_comb begin
    cnt_inc = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cnt_inc = cnt_inc + CNT_W'(lane_mask_i[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (in_fire) state_d = BUF_ONE;
      BUF_ONE: begin
        if (in_fire && !out_fire)      state_d = BUF_TWO;
        else if (out_fire && !in_fire) state_d = BUF_EMPTY;
      end
      BUF_TWO:   if (out_fire) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Flags are registered from the next state so in_ready has no path from out_ready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      head_mask_q <= '0;
      skid_mask_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_TWO);
      out_valid_q <= (state_d != BUF_EMPTY);
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire) begin
            head_q      <= dec_new;
            head_mask_q <= lane_mask_i;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            head_q      <= dec_new;
            head_mask_q <= lane_mask_i;
          end else if (in_fire) begin
            skid_q      <= dec_new;
            skid_mask_q <= lane_mask_i;
          end
        end
        BUF_TWO: begin
          if (out_fire) begin
            head_q      <= skid_q;
            head_mask_q <= skid_mask_q;
          end
        end
        default: ;
      endcase
      if (in_fire) cnt_q <= cnt_q + cnt_inc;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign lane_mask_o  = head_mask_q;
  assign decode_cnt_o = cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: single-lane sign/zero-extension
// instances and a two-lane instance with a 4-bit counter.
module tb_riscv_decode_stage;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  // single-lane stimulus shared by the sign- and zero-extending instances
  logic        in_valid1, out_ready1;
  logic [31:0] instr1;
  logic [0:0]  mask1;

  logic        in_ready1, out_valid1;
  logic [0:0]  lmask1, ill1;
  logic [2:0]  format1, f3_1;
  logic [6:0]  op1, f7_1;
  logic [4:0]  rd1, rs1_1, rs2_1;
  logic [31:0] imm1, cnt1;
  logic [1:0]  st1;

  logic        in_readyz, out_validz;
  logic [0:0]  lmaskz, illz;
  logic [2:0]  formatz, f3_z;
  logic [6:0]  opz, f7_z;
  logic [4:0]  rdz, rs1_z, rs2_z;
  logic [31:0] immz, cntz;
  logic [1:0]  stz;

  logic        in_valid2, out_ready2;
  logic [63:0] instr2;
  logic [1:0]  mask2;

  logic        in_ready2, out_valid2;
  logic [1:0]  lmask2, ill2;
  logic [5:0]  format2, f3_2;
  logic [13:0] op2, f7_2;
  logic [9:0]  rd2, rs1_2, rs2_2;
  logic [63:0] imm2;
  logic [3:0]  cnt2;
  logic [1:0]  st2;

  logic [31:0] exp_q[$];

  riscv_decode_stage #(.NUM_LANES(1), .SIGN_EXT_IMM(1), .CNT_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .instr_i(instr1), .lane_mask_i(mask1), .out_valid_o(out_valid1), .out_ready_i(out_ready1),
    .lane_mask_o(lmask1), .format_o(format1), .op_o(op1), .funct3_o(f3_1), .funct7_o(f7_1),
    .rd_o(rd1), .rs1_o(rs1_1), .rs2_o(rs2_1), .imm_o(imm1), .illegal_o(ill1),
    .decode_cnt_o(cnt1), .state_o(st1)
  );

  riscv_decode_stage #(.NUM_LANES(1), .SIGN_EXT_IMM(0), .CNT_W(32)) dutz (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_readyz),
    .instr_i(instr1), .lane_mask_i(mask1), .out_valid_o(out_validz), .out_ready_i(out_ready1),
    .lane_mask_o(lmaskz), .format_o(formatz), .op_o(opz), .funct3_o(f3_z), .funct7_o(f7_z),
    .rd_o(rdz), .rs1_o(rs1_z), .rs2_o(rs2_z), .imm_o(immz), .illegal_o(illz),
    .decode_cnt_o(cntz), .state_o(stz)
  );

  riscv_decode_stage #(.NUM_LANES(2), .SIGN_EXT_IMM(1), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .instr_i(instr2), .lane_mask_i(mask2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .lane_mask_o(lmask2), .format_o(format2), .op_o(op2), .funct3_o(f3_2), .funct7_o(f7_2),
    .rd_o(rd2), .rs1_o(rs1_2), .rs2_o(rs2_2), .imm_o(imm2), .illegal_o(ill2),
    .decode_cnt_o(cnt2), .state_o(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi_enc(input int n);
    return 32'((n << 20) | (n << 7) | 32'h13);
  endfunction

  task automatic apply_reset();
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic send1(input logic [31:0] ins);
    in_valid1 = 1'b1; instr1 = ins; mask1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [63:0] ins, input logic [1:0] m);
    in_valid2 = 1'b1; instr2 = ins; mask2 = m;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready1 = 1'b0; out_ready2 = 1'b0;
    instr1 = '0; mask1 = '0; instr2 = '0; mask2 = '0;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid1); else pass_cnt++;
    total_cnt++; if (in_ready1 !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready1); else pass_cnt++;
    total_cnt++; if (cnt1 !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", cnt1); else pass_cnt++;
    total_cnt++; if (imm1 !== 32'd0 || format1 !== 3'd0 || rd1 !== 5'd0)
      $display("FAIL reset_data got imm %h fmt %0d rd %0d exp 0", imm1, format1, rd1); else pass_cnt++;
    total_cnt++; if (out_valid2 !== 1'b0 || cnt2 !== 4'd0)
      $display("FAIL reset_dut2 got valid %0b cnt %0d exp 0/0", out_valid2, cnt2); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_addi();
    apply_reset();
    out_ready1 = 1'b1;
    send1(32'hFFF10093);
    total_cnt++; if (out_valid1 !== 1'b1) $display("FAIL addi_valid got %0b exp 1", out_valid1); else pass_cnt++;
    total_cnt++; if (format1 !== 3'd1) $display("FAIL addi_fmt got %0d exp 1", format1); else pass_cnt++;
    total_cnt++; if (rd1 !== 5'd1 || rs1_1 !== 5'd2) $display("FAIL addi_regs got rd %0d rs1 %0d exp 1/2", rd1, rs1_1); else pass_cnt++;
    total_cnt++; if (imm1 !== 32'hFFFFFFFF) $display("FAIL addi_imm got %h exp ffffffff", imm1); else pass_cnt++;
    total_cnt++; if (ill1 !== 1'b0) $display("FAIL addi_illegal got %0b exp 0", ill1); else pass_cnt++;
    total_cnt++; if (cnt1 !== 32'd1) $display("FAIL addi_cnt got %0d exp 1", cnt1); else pass_cnt++;
    total_cnt++; if (immz !== 32'h00000FFF) $display("FAIL addi_imm_zext got %h exp 00000fff", immz); else pass_cnt++;
  endtask

  task automatic test_imm();
    send1(32'hFE000EE3);
    total_cnt++; if (format1 !== 3'd3) $display("FAIL beq_fmt got %0d exp 3", format1); else pass_cnt++;
    total_cnt++; if (imm1 !== 32'hFFFFFFFC) $display("FAIL beq_imm got %h exp fffffffc", imm1); else pass_cnt++;
    total_cnt++; if (immz !== 32'h00001FFC) $display("FAIL beq_imm_zext got %h exp 00001ffc", immz); else pass_cnt++;
    send1(32'h001000EF);
    total_cnt++; if (format1 !== 3'd5 || rd1 !== 5'd1) $display("FAIL jal_fmt_rd got %0d/%0d exp 5/1", format1, rd1); else pass_cnt++;
    total_cnt++; if (imm1 !== 32'h00000800) $display("FAIL jal_imm got %h exp 00000800", imm1); else pass_cnt++;
    send1(32'h123452B7);
    total_cnt++; if (format1 !== 3'd4 || rd1 !== 5'd5) $display("FAIL lui_fmt_rd got %0d/%0d exp 4/5", format1, rd1); else pass_cnt++;
    total_cnt++; if (imm1 !== 32'h12345000 || immz !== 32'h12345000)
      $display("FAIL lui_imm got %h/%h exp 12345000", imm1, immz); else pass_cnt++;
    total_cnt++; if (cnt1 !== 32'd4) $display("FAIL imm_cnt got %0d exp 4", cnt1); else pass_cnt++;
  endtask

  task automatic test_two_lane();
    apply_reset();
    out_ready2 = 1'b1;
    send2({32'h00000013, 32'h00000000}, 2'b11);
    total_cnt++; if (format2[2:0] !== 3'd6 || ill2[0] !== 1'b1 || imm2[31:0] !== 32'd0)
      $display("FAIL lane0_err got fmt %0d ill %0b imm %h exp 6/1/0", format2[2:0], ill2[0], imm2[31:0]); else pass_cnt++;
    total_cnt++; if (format2[5:3] !== 3'd1 || ill2[1] !== 1'b0)
      $display("FAIL lane1_ok got fmt %0d ill %0b exp 1/0", format2[5:3], ill2[1]); else pass_cnt++;
    total_cnt++; if (cnt2 !== 4'd2 || lmask2 !== 2'b11) $display("FAIL two_lane_cnt got %0d mask %b exp 2/11", cnt2, lmask2); else pass_cnt++;
    send2({32'h00000013, 32'h00000000}, 2'b10);
    total_cnt++; if (ill2 !== 2'b00) $display("FAIL masked_illegal got %b exp 00", ill2); else pass_cnt++;
    total_cnt++; if (cnt2 !== 4'd3) $display("FAIL masked_cnt got %0d exp 3", cnt2); else pass_cnt++;
    send2({32'h00000013, 32'h00000000}, 2'b00);
    total_cnt++; if (out_valid2 !== 1'b1 || lmask2 !== 2'b00 || ill2 !== 2'b00)
      $display("FAIL zero_mask_fwd got valid %0b mask %b ill %b exp 1/00/00", out_valid2, lmask2, ill2); else pass_cnt++;
    total_cnt++; if (cnt2 !== 4'd3) $display("FAIL zero_mask_cnt got %0d exp 3", cnt2); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    out_ready2 = 1'b1;
    in_valid2 = 1'b1; instr2 = {32'h00000013, 32'h00000013}; mask2 = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      total_cnt++; if (cnt2 !== 4'((i + 1) * 2))
        $display("FAIL cnt_wrap_%0d got %0d exp %0d", i, cnt2, 4'((i + 1) * 2)); else pass_cnt++;
    end
    in_valid2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] bundles [4];
    logic [31:0] e;
    int sent, got, cyc;
    logic fire_in, fire_out, hold_pending;
    logic [4:0] hold_rd;
    apply_reset();
    for (int i = 0; i < 4; i++) bundles[i] = addi_enc(11 + i);
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; hold_pending = 1'b0; hold_rd = '0;
    mask1 = 1'b1;
    while (got < 4 && cyc < 40) begin
      out_ready1 = (cyc >= 3);
      in_valid1  = (sent < 4);
      if (sent < 4) instr1 = bundles[sent];
      if (hold_pending) begin
        total_cnt++; if (rd1 !== hold_rd) $display("FAIL hold_stable got rd %0d exp %0d", rd1, hold_rd); else pass_cnt++;
      end
      if (cyc == 2) begin
        total_cnt++; if (in_ready1 !== 1'b0) $display("FAIL bp_in_ready got %0b exp 0", in_ready1); else pass_cnt++;
      end
      fire_in  = in_valid1 && in_ready1;
      fire_out = out_valid1 && out_ready1;
      hold_pending = out_valid1 && !out_ready1;
      hold_rd = rd1;
      if (fire_out) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        total_cnt++; if (rd1 !== e[11:7] || imm1 !== {20'd0, e[31:20]})
          $display("FAIL bp_order_%0d got rd %0d imm %h exp rd %0d imm %h", got, rd1, imm1, e[11:7], {20'd0, e[31:20]});
        else pass_cnt++;
        got++;
      end
      if (fire_in) begin
        exp_q.push_back(bundles[sent]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid1 = 1'b0;
    total_cnt++; if (got !== 4) $display("FAIL bp_timeout got %0d bundles exp 4", got); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready1 = 1'b0;
    send1(addi_enc(7));
    send1(addi_enc(8));
    total_cnt++; if (in_ready1 !== 1'b0 || st1 !== 2'd2) $display("FAIL pre_reset_two got ready %0b st %0d exp 0/2", in_ready1, st1); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1)
      $display("FAIL async_reset_flags got valid %0b ready %0b exp 0/1", out_valid1, in_ready1); else pass_cnt++;
    total_cnt++; if (cnt1 !== 32'd0 || imm1 !== 32'd0) $display("FAIL async_reset_state got cnt %0d imm %h exp 0/0", cnt1, imm1); else pass_cnt++;
    #1 rst = 1'b0;
    out_ready1 = 1'b1;
    send1(addi_enc(9));
    total_cnt++; if (out_valid1 !== 1'b1 || rd1 !== 5'd9 || cnt1 !== 32'd1)
      $display("FAIL post_reset got valid %0b rd %0d cnt %0d exp 1/9/1", out_valid1, rd1, cnt1); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_addi();
    test_imm();
    test_two_lane();
    test_counter_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Registered, multi-lane RV32I instruction decode stage. It accepts a bundle of NUM_LANES instruction words through a valid/ready handshake and decodes each lane into format, opcode, funct fields, register indices, an immediate and an illegal flag.
- Results are buffered in a 2-entry skid buffer. Sits between the instruction-fetch model and the contract/trace checker in the verification environment.
- Generalises the single-lane combinational decoder: parametrised lane count, sign-extension mode, backpressure, illegal detection, and a decoded-instruction counter.

Parameters:
- NUM_LANES, 1, number of 32-bit instruction lanes per bundle (1..4).
- SIGN_EXT_IMM, 1, 1 = immediates sign-extended from their top encoded bit; 0 = zero-extended.
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  an instruction bundle is presented.
- in_ready_o  out  1  the stage can accept a bundle.
- instr_i  in  32*NUM_LANES  instruction words; lane k occupies bits [32k+31:32k].
- lane_mask_i  in  NUM_LANES  per-lane valid bits.
- out_valid_o  out  1  a decoded bundle is available.
- out_ready_i  in  1  the consumer accepts the bundle.
- lane_mask_o  out  NUM_LANES  registered copy of lane_mask_i.
- format_o  out  3*NUM_LANES  per-lane format code.
- op_o  out  7*NUM_LANES  opcode.
- funct3_o  out  3*NUM_LANES  funct3 field.
- funct7_o  out  7*NUM_LANES  funct7 field.
- rd_o / rs1_o / rs2_o  out  5*NUM_LANES each  register indices.
- imm_o  out  32*NUM_LANES  decoded immediate.
- illegal_o  out  NUM_LANES  lane illegal flag, forced 0 where the lane mask bit is 0.
- decode_cnt_o  out  CNT_W  count of decoded valid lanes.

Behaviour:
- Reset values (asynchronous, rst_i=1): out_valid_o=0, in_ready_o=1, decode_cnt_o=0, all data outputs=0, buffer state EMPTY.
- Handshakes:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - Data on the output is held stable while out_valid_o=1 && out_ready_i=0.
- Latency: a bundle accepted in cycle n appears on the outputs in cycle n+1 when the buffer was EMPTY. Throughput is one bundle per cycle while out_ready_i=1.
- Buffer FSM:
  - EMPTY:
    - in_fire -> ONE.
  - ONE:
    - in_fire && !out_fire -> TWO.
    - out_fire && !in_fire -> EMPTY.
    - in_fire && out_fire -> ONE, with the head replaced by the new bundle.
    - neither -> ONE.
  - TWO:
    - out_fire -> ONE; the skid entry moves to the head.
    - in_fire is impossible in TWO.
- Flag decoding: in_ready_o = (state != TWO), driven from a register with no combinational path from out_ready_i. out_valid_o = (state != EMPTY). Output order equals input order; no bundle is dropped or duplicated.
- Decoding is combinational, per lane, on instr_i before capture.
- Field extraction:
  - op = instr[6:0], funct3 = [14:12], funct7 = [31:25].
  - rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- Format by opcode:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - anything else -> ERR.
- Immediate by format (ext() means sign- or zero-extension per SIGN_EXT_IMM):
  - R and ERR -> 0.
  - I -> ext(instr[31:20]).
  - S -> ext({[31:25],[11:7]}).
  - B -> ext({[31],[7],[30:25],[11:8],1'b0}).
  - U -> {[31:12],12'b0}.
  - J -> ext({[31],[19:12],[20],[30:21],1'b0}).
- Illegal: illegal = (format==ERR) || (instr[1:0] != 2'b11).
- Counter:
  - On each in_fire, decode_cnt_o += popcount(lane_mask_i).
  - Modulo 2^CNT_W, with silent wrap.
  - Updates in the same edge as capture, so it is visible in cycle n+1.
- Boundary cases:
  - A bundle with lane_mask_i=0 is still accepted and forwarded, and the counter is unchanged.
  - Reset asserted mid-operation discards all buffered bundles immediately and returns the stage to its reset values.

Decomposition:
- Package riscv_decode_pkg holds:
  - format_e enum: R=0, I=1, S=2, B=3, U=4, J=5, ERR=6.
  - Opcode constants: OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC.
  - decoded_lane_t packed struct: format, op, funct3, funct7, rd, rs1, rs2, imm, illegal.
- Sub-module riscv_decode_lane: purely combinational single-lane decoder with the SIGN_EXT_IMM parameter, instantiated NUM_LANES times by a generate loop. The top level holds the skid-buffer FSM and the counter.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), SIGN_EXT_IMM=1, lane mask 1 -> one cycle later: format I, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0, decode_cnt_o=1. With SIGN_EXT_IMM=0 -> imm=0x00000FFF.
- Immediate reassembly:
  - beq x0,x0,-4 (0xFE000EE3) -> format B, imm=0xFFFFFFFC.
  - jal x1,+2048 (0x001000EF) -> format J, rd=1, imm=0x00000800.
  - lui x5,0x12345 (0x123452B7) -> format U, imm=0x12345000.
- NUM_LANES=2, lanes {0x00000000, 0x00000013}, mask 2'b11 -> lane 0 illegal=1, format ERR, imm=0; lane 1 format I, illegal=0. Same bundle with mask 2'b10 -> lane 0 illegal=0.
- Backpressure:
  - Stimulus: bundles A,B,C,D offered back-to-back while out_ready_i=0 for 3 cycles.
  - in_ready_o falls after A and B are held, and C waits.
  - On release, outputs are A,B,C,D in order, each held stable while stalled.
- Counter wrap: CNT_W=4, NUM_LANES=2, 8 bundles with mask 2'b11 -> decode_cnt_o reads 2,4,...,14, then 0.
- Reset mid-operation: pulse rst_i asynchronously while the buffer is in TWO -> out_valid_o=0, in_ready_o=1 and decode_cnt_o=0 before the next clock edge; the next accepted bundle appears after the usual one cycle.
